tdp_ram_ctrl: RTL and testbench

Parametrised true dual-port synchronous RAM; the next generation of the team's dual-port RAM. Both ports read and write independently, with byte-enabled writes, per-port read-valid flags, address-collision detection and a defined write priority. A clear state machine sweeps the array after reset, so contents are deterministic before first use. Used as shared scratch storage between two producer/consumer blocks.

---
 rtl/tdp_ram_pkg.sv | 17 +
 rtl/tdp_ram_ctrl_if.sv | 41 ++++
 rtl/tdp_ram_clr_fsm.sv | 66 ++++++
 rtl/tdp_ram_ctrl.sv | 146 ++++++++++++++
 tb/tb_tdp_ram_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdp_ram_pkg.sv
// Shared types and derived constants for the true dual-port RAM controller.
package tdp_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int DW_DEF = 8;
  localparam int BEW    = DW_DEF / 8;

  // Byte-enable width for a given data width.
  function automatic int bew(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/tdp_ram_ctrl_if.sv
// Two-port request/response bundle of the dual-port RAM, plus BUSY and COLL.
interface tdp_ram_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  import tdp_ram_pkg::*;

  localparam int BW = bew(DW);

  logic          PEN0;
  logic          WEN0;
  logic [BW-1:0] BE0;
  logic [AW-1:0] A0;
  logic [DW-1:0] DI0;
  logic [DW-1:0] DO0;
  logic          DV0;

  logic          PEN1;
  logic          WEN1;
  logic [BW-1:0] BE1;
  logic [AW-1:0] A1;
  logic [DW-1:0] DI1;
  logic [DW-1:0] DO1;
  logic          DV1;

  logic          COLL;
  logic          BUSY;

  modport master (
    output PEN0, WEN0, BE0, A0, DI0,
    output PEN1, WEN1, BE1, A1, DI1,
    input  DO0, DV0, DO1, DV1, COLL, BUSY
  );

  modport slave (
    input  PEN0, WEN0, BE0, A0, DI0,
    input  PEN1, WEN1, BE1, A1, DI1,
    output DO0, DV0, DO1, DV1, COLL, BUSY
  );

endinterface

// File: rtl/tdp_ram_clr_fsm.sv
// Post-reset clear sweep: walks every word once, then parks in READY until RST.
module tdp_ram_clr_fsm
  import tdp_ram_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_r;
  clr_state_e    state_nxt_s;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_nxt_s;
  logic          busy_r;
  logic          clr_we_s;

  // State, sweep pointer and BUSY registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      ptr_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= (state_nxt_s == CLEAR);
    end
  end

  // Next-state and sweep-write decode.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    clr_we_s    = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (ptr_r == LAST) begin
          state_nxt_s = READY;
          ptr_nxt_s   = {AW{1'b0}};
        end else begin
          ptr_nxt_s = ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      READY: begin
        state_nxt_s = READY;
      end
      default: begin
        state_nxt_s = CLEAR;
        ptr_nxt_s   = {AW{1'b0}};
      end
    endcase
  end

  assign busy     = busy_r;
  assign clr_we   = clr_we_s;
  assign clr_addr = ptr_r;

endmodule

// File: rtl/tdp_ram_ctrl.sv
// True dual-port RAM with byte enables, read-first collisions and a post-reset clear sweep.
// Define TDP_OUTREG_EN to add an output pipeline stage (read latency 2).
module tdp_ram_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            AW      = 4,
  parameter int            DEPTH   = 16,
  parameter int            WR_PRIO = 0,
  parameter logic [DW-1:0] CLR_VAL = {DW{1'b0}}
) (
  input logic           CLK,
  input logic           RST,
  tdp_ram_ctrl_if.slave bus
);

  localparam int BW = bew(DW);

  logic [DW-1:0] mem_r [DEPTH];

  logic          busy_s;
  logic          clr_we_s;
  logic [AW-1:0] clr_addr_s;

  logic          in0_s, in1_s, same_s;
  logic          rd0_s, rd1_s, req0_s, req1_s, win0_s, win1_s, coll_s;
  logic          wr0_en_s;
  logic [AW-1:0] wr0_addr_s;
  logic [DW-1:0] wr0_data_s;
  logic [BW-1:0] wr0_be_s;

  logic [DW-1:0] do0_r, do1_r;
  logic          dv0_r, dv1_r, coll_r;

  tdp_ram_clr_fsm #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_clr (
    .clk      (CLK),
    .rst      (RST),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Request decode, write arbitration and the sweep mux onto port 0.
  always_comb begin
    in0_s  = (int'(bus.A0) < DEPTH);
    in1_s  = (int'(bus.A1) < DEPTH);
    same_s = (bus.A0 == bus.A1);
    rd0_s  = !busy_s && bus.PEN0 && !bus.WEN0;
    rd1_s  = !busy_s && bus.PEN1 && !bus.WEN1;
    req0_s = !busy_s && bus.PEN0 && bus.WEN0 && in0_s;
    req1_s = !busy_s && bus.PEN1 && bus.WEN1 && in1_s;
    coll_s = !busy_s && bus.PEN0 && bus.PEN1 && same_s && (bus.WEN0 || bus.WEN1);
    // The losing port of a same-address write is dropped whole, never merged.
    if (req0_s && req1_s && same_s) begin
      win0_s = (WR_PRIO == 0);
      win1_s = (WR_PRIO != 0);
    end else begin
      win0_s = req0_s;
      win1_s = req1_s;
    end
    if (busy_s) begin
      wr0_en_s   = clr_we_s;
      wr0_addr_s = clr_addr_s;
      wr0_data_s = CLR_VAL;
      wr0_be_s   = {BW{1'b1}};
    end else begin
      wr0_en_s   = win0_s;
      wr0_addr_s = bus.A0;
      wr0_data_s = bus.DI0;
      wr0_be_s   = bus.BE0;
    end
  end

  // Byte-enabled array writes from both ports.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < BW; b++) begin
      if (wr0_en_s && wr0_be_s[b]) begin
        mem_r[wr0_addr_s][b*8 +: 8] <= wr0_data_s[b*8 +: 8];
      end
      if (win1_s && bus.BE1[b]) begin
        mem_r[bus.A1][b*8 +: 8] <= bus.DI1[b*8 +: 8];
      end
    end
  end

  // Read-first data, valid flags and collision flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      do0_r  <= {DW{1'b0}};
      do1_r  <= {DW{1'b0}};
      dv0_r  <= 1'b0;
      dv1_r  <= 1'b0;
      coll_r <= 1'b0;
    end else begin
      dv0_r  <= rd0_s;
      dv1_r  <= rd1_s;
      coll_r <= coll_s;
      if (rd0_s) begin
        do0_r <= in0_s ? mem_r[bus.A0] : {DW{1'b0}};
      end
      if (rd1_s) begin
        do1_r <= in1_s ? mem_r[bus.A1] : {DW{1'b0}};
      end
    end
  end

`ifdef TDP_OUTREG_EN
  logic [DW-1:0] do0_p_r, do1_p_r;
  logic          dv0_p_r, dv1_p_r, coll_p_r;

  // Output pipeline stage, flushed while the sweep runs.
  always_ff @(posedge CLK) begin
    if (RST || busy_s) begin
      do0_p_r  <= {DW{1'b0}};
      do1_p_r  <= {DW{1'b0}};
      dv0_p_r  <= 1'b0;
      dv1_p_r  <= 1'b0;
      coll_p_r <= 1'b0;
    end else begin
      do0_p_r  <= do0_r;
      do1_p_r  <= do1_r;
      dv0_p_r  <= dv0_r;
      dv1_p_r  <= dv1_r;
      coll_p_r <= coll_r;
    end
  end

  assign bus.DO0  = do0_p_r;
  assign bus.DO1  = do1_p_r;
  assign bus.DV0  = dv0_p_r;
  assign bus.DV1  = dv1_p_r;
  assign bus.COLL = coll_p_r;
`else
  assign bus.DO0  = do0_r;
  assign bus.DO1  = do1_r;
  assign bus.DV0  = dv0_r;
  assign bus.DV1  = dv1_r;
  assign bus.COLL = coll_r;
`endif

  assign bus.BUSY = busy_s;

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// Directed bench: an 8-bit/16-deep instance (port 0 priority) and a 16-bit/12-deep one (port 1 priority).
module tb_tdp_ram_ctrl;

`ifdef TDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_a;
  int   cnt_b;

  always #5 clk = ~clk;

  tdp_ram_ctrl_if #(.DW(8),  .AW(4)) ifa ();
  tdp_ram_ctrl_if #(.DW(16), .AW(4)) ifb ();

  tdp_ram_ctrl #(.DW(8), .AW(4), .DEPTH(16), .WR_PRIO(0), .CLR_VAL(8'h00)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (ifa.slave)
  );

  tdp_ram_ctrl #(.DW(16), .AW(4), .DEPTH(12), .WR_PRIO(1), .CLR_VAL(16'hA5A5)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.PEN0 = 1'b0; ifa.WEN0 = 1'b0; ifa.PEN1 = 1'b0; ifa.WEN1 = 1'b0;
    ifb.PEN0 = 1'b0; ifb.WEN0 = 1'b0; ifb.PEN1 = 1'b0; ifb.WEN1 = 1'b0;
  endtask

  task automatic lat_wait();
    idle();
    if (LAT == 2) tick();
  endtask

  task automatic wr_a(input int p, input logic [3:0] addr, input logic [7:0] data);
    if (p == 0) begin
      ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b1; ifa.A0 = addr; ifa.DI0 = data; ifa.BE0 = 1'b1;
    end else begin
      ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b1; ifa.A1 = addr; ifa.DI1 = data; ifa.BE1 = 1'b1;
    end
    tick();
    idle();
  endtask

  task automatic rd_a(input int p, input logic [3:0] addr, input logic [7:0] exp, input string tag);
    if (p == 0) begin
      ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b0; ifa.A0 = addr;
    end else begin
      ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b0; ifa.A1 = addr;
    end
    tick();
    lat_wait();
    if (p == 0) begin
      check({tag, ".do0"}, ifa.DO0, exp);
      check({tag, ".dv0"}, ifa.DV0, 1);
    end else begin
      check({tag, ".do1"}, ifa.DO1, exp);
      check({tag, ".dv1"}, ifa.DV1, 1);
    end
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    ifb.PEN0 = 1'b1; ifb.WEN0 = 1'b1; ifb.A0 = addr; ifb.DI0 = data; ifb.BE0 = be;
    tick();
    idle();
  endtask

  task automatic rd_b(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    ifb.PEN0 = 1'b1; ifb.WEN0 = 1'b0; ifb.A0 = addr;
    tick();
    lat_wait();
    check({tag, ".do0"}, ifb.DO0, exp);
    check({tag, ".dv0"}, ifb.DV0, 1);
  endtask

  // Counts cycles each instance reports BUSY; bounded so a stuck sweep still ends.
  task automatic count_busy(input bit mid_chk);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.BUSY) cnt_a++;
      if (ifb.BUSY) cnt_b++;
      if (!ifa.BUSY && !ifb.BUSY) break;
      if (mid_chk && i == 6) begin
        check("sweep.dv0", ifa.DV0, 0);
        check("sweep.coll", ifa.COLL, 0);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    ifa.A0 = 4'd0; ifa.A1 = 4'd0; ifa.DI0 = 8'h00; ifa.DI1 = 8'h00; ifa.BE0 = 1'b0; ifa.BE1 = 1'b0;
    ifb.A0 = 4'd0; ifb.A1 = 4'd0; ifb.DI0 = 16'h0000; ifb.DI1 = 16'h0000; ifb.BE0 = 2'b00; ifb.BE1 = 2'b00;

    // Reset state
    tick();
    tick();
    check("rst.busy", ifa.BUSY, 1);
    check("rst.do0", ifa.DO0, 0);
    check("rst.dv0", ifa.DV0, 0);
    check("rst.dv1", ifa.DV1, 0);
    check("rst.coll", ifa.COLL, 0);
    rst = 1'b0;
    count_busy(1'b0);
    check("sweep1.busy_a", cnt_a, 16);
    check("sweep1.busy_b", cnt_b, 12);

    // Cleared contents
    for (int i = 0; i < 16; i++) rd_a(0, 4'(i), 8'h00, "clr_rd");
    rd_b(4'd0, 16'hA5A5, "clr_rd_b");

    // Fill via port 0, read back via port 1
    for (int i = 1; i <= 16; i++) begin
      wr_a(0, 4'(i - 1), 8'(i));
      if (i == 1) begin
        lat_wait();
        check("wr.dv0", ifa.DV0, 0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      rd_a(1, 4'(i), 8'(i + 1), "fill_rd");
      check("fill_rd.coll", ifa.COLL, 0);
    end

    // Idle port holds its last data
    tick();
    check("hold.dv1", ifa.DV1, 0);
    check("hold.do1", ifa.DO1, 8'h10);

    // Write/write collision at address 5
    ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b1; ifa.A0 = 4'd5; ifa.DI0 = 8'hAA; ifa.BE0 = 1'b1;
    ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b1; ifa.A1 = 4'd5; ifa.DI1 = 8'h55; ifa.BE1 = 1'b1;
    ifb.PEN0 = 1'b1; ifb.WEN0 = 1'b1; ifb.A0 = 4'd5; ifb.DI0 = 16'h00AA; ifb.BE0 = 2'b11;
    ifb.PEN1 = 1'b1; ifb.WEN1 = 1'b1; ifb.A1 = 4'd5; ifb.DI1 = 16'h0055; ifb.BE1 = 2'b11;
    tick();
    lat_wait();
    check("ww.coll_a", ifa.COLL, 1);
    check("ww.coll_b", ifb.COLL, 1);
    rd_a(0, 4'd5, 8'hAA, "ww_rd_a");
    check("ww.coll_clr", ifa.COLL, 0);
    rd_b(4'd5, 16'h0055, "ww_rd_b");

    // Read-first on a read/write collision at address 3
    wr_a(0, 4'd3, 8'h11);
    ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b1; ifa.A0 = 4'd3; ifa.DI0 = 8'h99; ifa.BE0 = 1'b1;
    ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b0; ifa.A1 = 4'd3;
    tick();
    lat_wait();
    check("rw.do1", ifa.DO1, 8'h11);
    check("rw.dv1", ifa.DV1, 1);
    check("rw.dv0", ifa.DV0, 0);
    check("rw.coll", ifa.COLL, 1);
    rd_a(1, 4'd3, 8'h99, "rw_after");

    // Two reads of one address: no collision
    ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b0; ifa.A0 = 4'd7;
    ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b0; ifa.A1 = 4'd7;
    tick();
    lat_wait();
    check("rr.do0", ifa.DO0, 8'h08);
    check("rr.do1", ifa.DO1, 8'h08);
    check("rr.coll", ifa.COLL, 0);

    // Byte enables on the 16-bit instance
    wr_b(4'd2, 16'hBEEF, 2'b11);
    wr_b(4'd2, 16'h1234, 2'b01);
    rd_b(4'd2, 16'hBE34, "be_rd");

    // Out-of-range address on the 12-deep instance
    wr_b(4'd13, 16'h7777, 2'b11);
    rd_b(4'd13, 16'h0000, "oor_rd");
    rd_b(4'd11, 16'hA5A5, "oor_neighbour");

    // Reset part way through a sweep restarts it from zero
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.PEN0 = 1'b1; ifa.WEN0 = 1'b0; ifa.A0 = 4'd3;
    ifa.PEN1 = 1'b1; ifa.WEN1 = 1'b1; ifa.A1 = 4'd3; ifa.DI1 = 8'hFF; ifa.BE1 = 1'b1;
    count_busy(1'b1);
    idle();
    check("sweep2.busy_a", cnt_a, 16);
    check("sweep2.busy_b", cnt_b, 12);
    rd_a(0, 4'd3, 8'h00, "sweep2_rd");
    rd_a(1, 4'd15, 8'h00, "sweep2_rd15");
    rd_b(4'd2, 16'hA5A5, "sweep2_rd_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
